// File: rtl/lcd_timing_gen.sv
// LCD panel timing generator: hsync/vsync/de, pixel request and coordinates.
// Counters and FSM states are registered; outputs are registered from next state.
module lcd_timing_gen #(
   parameter logic [10:0] H_SYNC  = 11'd128,
   parameter logic [10:0] H_BACK  = 11'd88,
   parameter logic [10:0] H_DISP  = 11'd800,
   parameter logic [10:0] H_FRONT = 11'd40,
   parameter logic [10:0] V_SYNC  = 11'd2,
   parameter logic [10:0] V_BACK  = 11'd33,
   parameter logic [10:0] V_DISP  = 11'd480,
   parameter logic [10:0] V_FRONT = 11'd10
) (
   input  logic        lcd_pclk,
   input  logic        rst_n,
   input  logic [23:0] pixel_data,
   output logic [10:0] pixel_xpos,
   output logic [10:0] pixel_ypos,
   output logic [10:0] h_disp,
   output logic [10:0] v_disp,
   output logic        data_req,
   output logic        lcd_de,
   output logic        lcd_hs,
   output logic        lcd_vs,
   output logic [23:0] lcd_rgb,
   output logic        frame_start,
   output logic        lcd_bl
);

   localparam logic [10:0] H_DS    = H_SYNC + H_BACK;
   localparam logic [10:0] H_DE    = H_DS + H_DISP;
   localparam logic [10:0] H_TOTAL = H_DE + H_FRONT;
   localparam logic [10:0] V_DS    = V_SYNC + V_BACK;
   localparam logic [10:0] V_DE    = V_DS + V_DISP;
   localparam logic [10:0] V_TOTAL = V_DE + V_FRONT;

   typedef enum logic [1:0] {HSYNC, HBACK, HDISP, HFRONT} h_state_e;
   typedef enum logic [1:0] {VSYNC, VBACK, VDISP, VFRONT} v_state_e;

   h_state_e    h_state_q, h_state_d;
   v_state_e    v_state_q, v_state_d;
   logic [10:0] h_cnt_q, h_cnt_d;
   logic [10:0] v_cnt_q, v_cnt_d;
   logic        h_wrap, v_wrap;

   logic        hs_q, hs_d;
   logic        vs_q, vs_d;
   logic        de_q, de_d;
   logic        req_q, req_d;
   logic        fs_q, fs_d;
   logic        bl_q;
   logic [10:0] xpos_q, xpos_d;
   logic [10:0] ypos_q, ypos_d;

   assign h_wrap = (h_cnt_q == H_TOTAL - 11'd1);
   assign v_wrap = (v_cnt_q == V_TOTAL - 11'd1);

   // Next counter values: h free-runs, v advances only at the line wrap.
   always_comb begin
      h_cnt_d = h_wrap ? 11'd0 : h_cnt_q + 11'd1;
      v_cnt_d = v_cnt_q;
      if (h_wrap) begin
         v_cnt_d = v_wrap ? 11'd0 : v_cnt_q + 11'd1;
      end
   end

   // Next FSM states, changing only at the counter boundaries.
   always_comb begin
      h_state_d = h_state_q;
      unique case (h_state_q)
         HSYNC:  if (h_cnt_q == H_SYNC - 11'd1) h_state_d = HBACK;
         HBACK:  if (h_cnt_q == H_DS - 11'd1)   h_state_d = HDISP;
         HDISP:  if (h_cnt_q == H_DE - 11'd1)   h_state_d = HFRONT;
         HFRONT: if (h_wrap)                    h_state_d = HSYNC;
      endcase
      v_state_d = v_state_q;
      if (h_wrap) begin
         unique case (v_state_q)
            VSYNC:  if (v_cnt_q == V_SYNC - 11'd1) v_state_d = VBACK;
            VBACK:  if (v_cnt_q == V_DS - 11'd1)   v_state_d = VDISP;
            VDISP:  if (v_cnt_q == V_DE - 11'd1)   v_state_d = VFRONT;
            VFRONT: if (v_wrap)                    v_state_d = VSYNC;
         endcase
      end
   end

   // Output decode on the next state so the registered outputs line up with it.
   always_comb begin
      hs_d   = (h_state_d != HSYNC);
      vs_d   = (v_state_d != VSYNC);
      de_d   = (h_state_d == HDISP) && (v_state_d == VDISP);
      req_d  = (v_state_d == VDISP)
            && (h_cnt_d >= H_DS - 11'd1)
            && (h_cnt_d <  H_DE - 11'd1);
      xpos_d = req_d ? h_cnt_d - (H_DS - 11'd1) : 11'd0;
      ypos_d = (v_state_d == VDISP) ? v_cnt_d - V_DS : 11'd0;
      fs_d   = de_d && (v_cnt_d == V_DS) && (h_cnt_d == H_DS);
   end

   // Timing FSM: counters, states and registered outputs.
   always_ff @(posedge lcd_pclk or negedge rst_n) begin
      if (!rst_n) begin
         h_cnt_q   <= 11'd0;
         v_cnt_q   <= 11'd0;
         h_state_q <= HSYNC;
         v_state_q <= VSYNC;
         hs_q      <= 1'b0;
         vs_q      <= 1'b0;
         de_q      <= 1'b0;
         req_q     <= 1'b0;
         fs_q      <= 1'b0;
         xpos_q    <= 11'd0;
         ypos_q    <= 11'd0;
      end else begin
         h_cnt_q   <= h_cnt_d;
         v_cnt_q   <= v_cnt_d;
         h_state_q <= h_state_d;
         v_state_q <= v_state_d;
         hs_q      <= hs_d;
         vs_q      <= vs_d;
         de_q      <= de_d;
         req_q     <= req_d;
         fs_q      <= fs_d;
         xpos_q    <= xpos_d;
         ypos_q    <= ypos_d;
      end
   end

   // Backlight turns on at the first clock after reset and stays on.
   always_ff @(posedge lcd_pclk or negedge rst_n) begin
      if (!rst_n) begin
         bl_q <= 1'b0;
      end else begin
         bl_q <= 1'b1;
      end
   end

   assign lcd_hs      = hs_q;
   assign lcd_vs      = vs_q;
   assign lcd_de      = de_q;
   assign data_req    = req_q;
   assign frame_start = fs_q;
   assign pixel_xpos  = xpos_q;
   assign pixel_ypos  = ypos_q;
   assign lcd_bl      = bl_q;
   assign h_disp      = H_DISP;
   assign v_disp      = V_DISP;
   assign lcd_rgb     = de_q ? pixel_data : 24'h000000;

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Directed bench for lcd_timing_gen with a small 20x10 timing.
// Line = 4 sync + 4 back + 8 active + 4 front; frame = 2/2/4/2 lines.
module tb_lcd_timing_gen;

   logic        lcd_pclk;
   logic        rst_n;
   logic [23:0] pixel_data;
   logic [10:0] pixel_xpos;
   logic [10:0] pixel_ypos;
   logic [10:0] h_disp;
   logic [10:0] v_disp;
   logic        data_req;
   logic        lcd_de;
   logic        lcd_hs;
   logic        lcd_vs;
   logic [23:0] lcd_rgb;
   logic        frame_start;
   logic        lcd_bl;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int de_cnt = 0;
   int fs_cnt = 0;
   bit ff_mode = 1'b0;

   lcd_timing_gen #(
      .H_SYNC (11'd4), .H_BACK(11'd4), .H_DISP(11'd8), .H_FRONT(11'd4),
      .V_SYNC (11'd2), .V_BACK(11'd2), .V_DISP(11'd4), .V_FRONT(11'd2)
   ) dut (
      .lcd_pclk   (lcd_pclk),
      .rst_n      (rst_n),
      .pixel_data (pixel_data),
      .pixel_xpos (pixel_xpos),
      .pixel_ypos (pixel_ypos),
      .h_disp     (h_disp),
      .v_disp     (v_disp),
      .data_req   (data_req),
      .lcd_de     (lcd_de),
      .lcd_hs     (lcd_hs),
      .lcd_vs     (lcd_vs),
      .lcd_rgb    (lcd_rgb),
      .frame_start(frame_start),
      .lcd_bl     (lcd_bl)
   );

   initial lcd_pclk = 1'b0;
   always #5 lcd_pclk = ~lcd_pclk;

   task automatic check(input string tag, input logic [23:0] obs,
                        input logic [23:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc, obs, exp);
      end
   endtask

   // Advance one pclk; the pixel source answers the previous xpos one cycle late.
   task automatic step();
      logic [23:0] nxt;
      nxt = ff_mode ? 24'hFFFFFF : {13'd0, pixel_xpos};
      @(posedge lcd_pclk);
      #1;
      pixel_data = nxt;
      #1;
      cyc++;
   endtask

   task automatic check_reset_outputs();
      check("rst_hs",   {23'd0, lcd_hs},      24'd0);
      check("rst_vs",   {23'd0, lcd_vs},      24'd0);
      check("rst_de",   {23'd0, lcd_de},      24'd0);
      check("rst_req",  {23'd0, data_req},    24'd0);
      check("rst_x",    {13'd0, pixel_xpos},  24'd0);
      check("rst_y",    {13'd0, pixel_ypos},  24'd0);
      check("rst_rgb",  lcd_rgb,              24'd0);
      check("rst_fs",   {23'd0, frame_start}, 24'd0);
      check("rst_bl",   {23'd0, lcd_bl},      24'd0);
   endtask

   // Expected outputs for cycle c counted from the last reset release.
   task automatic check_cycle(input int c);
      int  fc, hc, vc;
      bit  vact, e_de, e_req;
      logic [23:0] e_rgb;
      fc    = c % 200;
      hc    = fc % 20;
      vc    = fc / 20;
      vact  = (vc >= 4) && (vc < 8);
      e_de  = vact && (hc >= 8) && (hc < 16);
      e_req = vact && (hc >= 7) && (hc < 15);
      if (!e_de)        e_rgb = 24'd0;
      else if (ff_mode) e_rgb = 24'hFFFFFF;
      else              e_rgb = 24'(hc - 8);
      check("hs",  {23'd0, lcd_hs},   24'(hc >= 4));
      check("vs",  {23'd0, lcd_vs},   24'(vc >= 2));
      check("de",  {23'd0, lcd_de},   24'(e_de));
      check("req", {23'd0, data_req}, 24'(e_req));
      check("x",   {13'd0, pixel_xpos}, e_req ? 24'(hc - 7) : 24'd0);
      check("y",   {13'd0, pixel_ypos}, vact ? 24'(vc - 4) : 24'd0);
      check("fs",  {23'd0, frame_start}, 24'(fc == 88));
      check("rgb", lcd_rgb, e_rgb);
      check("bl",  {23'd0, lcd_bl}, 24'(c >= 1));
      if (lcd_de) de_cnt++;
      if (frame_start) fs_cnt++;
   endtask

   initial begin
      rst_n      = 1'b0;
      pixel_data = 24'hFFFFFF;
      repeat (3) @(posedge lcd_pclk);
      #2;
      check_reset_outputs();
      check("h_disp", {13'd0, h_disp}, 24'd8);
      check("v_disp", {13'd0, v_disp}, 24'd4);

      @(posedge lcd_pclk);
      #1;
      rst_n      = 1'b1;
      pixel_data = 24'd0;
      #1;
      cyc = 0;

      // Frame 0 with echoed xpos data.
      check_cycle(cyc);
      while (cyc < 199) begin
         step();
         check_cycle(cyc);
      end
      check("de_cnt", 24'(de_cnt), 24'd32);
      check("fs_cnt", 24'(fs_cnt), 24'd1);

      // Frame wrap and constant white data into frame 1.
      ff_mode = 1'b1;
      fs_cnt  = 0;
      while (cyc < 295) begin
         step();
         check_cycle(cyc);
      end
      check("fs_cnt_f1", 24'(fs_cnt), 24'd1);

      // Reset mid-active line; outputs must drop without a clock edge.
      check("pre_rst_de", {23'd0, lcd_de}, 24'd1);
      rst_n = 1'b0;
      #1;
      check_reset_outputs();
      repeat (3) begin
         @(posedge lcd_pclk);
         #2;
         check_reset_outputs();
      end

      @(posedge lcd_pclk);
      #1;
      ff_mode    = 1'b0;
      rst_n      = 1'b1;
      pixel_data = 24'd0;
      #1;
      cyc    = 0;
      fs_cnt = 0;
      de_cnt = 0;
      check_cycle(cyc);
      while (cyc < 100) begin
         step();
         check_cycle(cyc);
      end
      check("fs_cnt_rst", 24'(fs_cnt), 24'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/lcd_timing_gen.md
LCD_TIMING_GEN -- requirements
Module: lcd_timing_gen

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- H_SYNC, 11'd128, hsync pulse width in pclk
- H_BACK, 11'd88, horizontal back porch
- H_DISP, 11'd800, active pixels per line
- H_FRONT, 11'd40, horizontal front porch
- V_SYNC, 11'd2, vsync width in lines
- V_BACK, 11'd33, vertical back porch
- V_DISP, 11'd480, active lines
- V_FRONT, 11'd10, vertical front porch

REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- lcd_pclk, in, 1, pixel clock
- rst_n, in, 1, reset, asynchronous, active-low
- pixel_data, in, 24, RGB888 from pixel generator, valid one cycle after request
- pixel_xpos, out, 11, requested column
- pixel_ypos, out, 11, requested row
- h_disp, out, 11, constant H_DISP
- v_disp, out, 11, constant V_DISP
- data_req, out, 1, pixel request strobe
- lcd_de, out, 1, data enable
- lcd_hs, out, 1, hsync, active-low
- lcd_vs, out, 1, vsync, active-low
- lcd_rgb, out, 24, panel data
- frame_start, out, 1, one-cycle pulse at first active pixel of frame
- lcd_bl, out, 1, backlight enable

REQ-003 Clock SHALL be lcd_pclk; reset SHALL be rst_n, asynchronous, active-low; all flops SHALL use only these.

Function
REQ-004 h_cnt (11 bit) SHALL count 0..H_TOTAL-1 (H_TOTAL = sum of H_*), wrapping to 0.
REQ-005 v_cnt (11 bit) SHALL increment only on cycles where h_cnt = H_TOTAL-1, count 0..V_TOTAL-1, wrap to 0.
REQ-006 Horizontal FSM states SHALL be HSYNC (h_cnt < H_SYNC), HBACK, HDISP (H_SYNC+H_BACK <= h_cnt < H_SYNC+H_BACK+H_DISP), HFRONT; transitions occur only at those h_cnt boundaries; HFRONT->HSYNC at the wrap.
REQ-007 Vertical FSM states VSYNC, VBACK, VDISP, VFRONT SHALL mirror REQ-006 on v_cnt, evaluated only at the line wrap.
REQ-008 lcd_hs SHALL be 0 in HSYNC, else 1; lcd_vs SHALL be 0 in VSYNC, else 1.
REQ-009 lcd_de SHALL be 1 iff horizontal state is HDISP and vertical state is VDISP.
REQ-010 data_req SHALL be 1 iff v in VDISP and H_SYNC+H_BACK-1 <= h_cnt < H_SYNC+H_BACK+H_DISP-1, i.e. exactly one cycle ahead of lcd_de.
REQ-011 pixel_xpos SHALL equal h_cnt-(H_SYNC+H_BACK-1) while data_req=1 (range 0..H_DISP-1), else 0.
REQ-012 pixel_ypos SHALL equal v_cnt-(V_SYNC+V_BACK) while v in VDISP (range 0..V_DISP-1), else 0.
REQ-013 lcd_rgb SHALL equal pixel_data when lcd_de=1, else 24'h000000; pixel_data sampled on the cycle after data_req gives the pixel at that xpos.
REQ-014 frame_start SHALL pulse 1 for exactly the cycle where lcd_de first rises in a frame (v_cnt = V_SYNC+V_BACK, h_cnt = H_SYNC+H_BACK).
REQ-015 h_disp/v_disp SHALL be constant parameter values, independent of reset.
REQ-016 lcd_bl SHALL be 0 in reset and go 1 on the first lcd_pclk edge after rst_n deassertion, staying 1.
REQ-017 All control outputs SHALL be decoded from registered counters/states only; no combinational path from pixel_data to any output other than lcd_rgb.

Reset
REQ-018 While rst_n=0: h_cnt=0, v_cnt=0, states HSYNC/VSYNC, lcd_hs=0, lcd_vs=0, lcd_de=0, data_req=0, pixel_xpos=0, pixel_ypos=0, lcd_rgb=0, frame_start=0, lcd_bl=0.
REQ-019 Reset asserted mid-line or mid-frame SHALL abort immediately; after release timing SHALL restart from h_cnt=0, v_cnt=0 with no partial-frame frame_start.

Verification (override H 4/4/8/4 =20, V 2/2/4/2 =10)
REQ-020 Release reset, count 200 pclk -> lcd_hs low cycles 0-3 of each 20-cycle line, lcd_vs low for first 40 cycles of each 200-cycle frame.
REQ-021 Line 4, pixel_data = {8'h0,xpos} echoed with one-cycle delay -> data_req at h_cnt 7..14, lcd_de at h_cnt 8..15, lcd_rgb = 0..7 in order, xpos 0..7.
REQ-022 Full frame -> lcd_de high exactly 32 cycles, pixel_ypos 0..3 on lines 4..7, frame_start once at cycle 88.
REQ-023 Frame wrap -> cycle 199 to 200: h_cnt 19->0 and v_cnt 9->0 same edge, lcd_vs falls, no extra frame_start.
REQ-024 Assert rst_n=0 at cycle 95 (mid-active) for 3 cycles -> all outputs at reset values same cycle asynchronously; after release frame_start next at 88 cycles later.
REQ-025 pixel_data = 24'hFFFFFF constant -> lcd_rgb = 24'hFFFFFF only when lcd_de=1, 0 in all blanking cycles.
